// File: rtl/reg_bus_master.sv
// Register-bus initiator.
// Takes RISC-V style load/store requests (byte address + funct3 size code) over a
// valid/ready handshake, runs one bus cycle per legal request, and returns
// lane-extracted, sign/zero-extended load data over a valid/ready response channel.
// Illegal, misaligned or out-of-lane accesses complete with rsp_err=1 and never
// touch the bus.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_addr, req_funct3, req_wdata   request payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    response payload (rdata is 0 for stores and errors)
//   addr, wben, r_wn, wdata   bus outputs (idle: r_wn=1, wben=00, wdata=0)
//   rdata                 bus read data, valid RD_LATENCY cycles after the read
module reg_bus_master #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  addr,
  output logic [1:0]  wben,
  output logic        r_wn,
  output logic [31:0] wdata,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0] LatInit = 3'(RD_LATENCY);

  state_e state_q, state_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  addr_q, addr_d;
  logic [1:0]  wben_q, wben_d;
  logic        r_wn_q, r_wn_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;

  logic        accept;
  logic        legal;
  logic [1:0]  st_wben;
  logic [31:0] st_wdata;

  assign accept = req_valid && req_ready_q;

  // Request legality: size code, alignment, and stores restricted to lanes 0-1.
  always_comb begin
    legal = 1'b1;
    case (req_funct3)
      3'b000:         if (req_we && req_addr[1]) legal = 1'b0;
      3'b001:         if (req_addr[0] || (req_we && req_addr[1])) legal = 1'b0;
      3'b010:         if (req_addr[1:0] != 2'b00) legal = 1'b0;
      3'b100, 3'b101: if (req_we || (req_funct3[0] && req_addr[0])) legal = 1'b0;
      default:        legal = 1'b0;
    endcase
  end

  // Store lane mapping; only meaningful for legal stores.
  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        if (req_addr[0]) begin
          st_wben  = 2'b10;
          st_wdata = {16'h0000, req_wdata[7:0], 8'h00};
        end else begin
          st_wben  = 2'b01;
          st_wdata = {24'h000000, req_wdata[7:0]};
        end
      end
      2'b01: begin
        st_wben  = 2'b11;
        st_wdata = {16'h0000, req_wdata[15:0]};
      end
      default: begin
        st_wben  = 2'b11;
        st_wdata = req_wdata;
      end
    endcase
  end

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h000000, b};
      3'b101:  extract = {16'h0000, h};
      default: extract = word;
    endcase
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      wben_q      <= '0;
      r_wn_q      <= 1'b1;
      wdata_q     <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      f3_q        <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      wben_q      <= wben_d;
      r_wn_q      <= r_wn_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = legal ? StIssue : StResp;
      StIssue: state_d = we_q ? StResp : StWait;
      StWait:  if (cnt_q == 3'd1) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs. The bus strobes default to idle, so
  // anything loaded on the accept edge is a single-cycle pulse in ISSUE.
  always_comb begin
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wben_d      = 2'b00;
    r_wn_d      = 1'b1;
    wdata_d     = '0;
    cnt_d       = cnt_q;
    we_d        = we_q;
    off_d       = off_q;
    f3_d        = f3_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          we_d  = req_we;
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          if (legal) begin
            addr_d = req_addr[4:2];
            if (req_we) begin
              r_wn_d  = 1'b0;
              wben_d  = st_wben;
              wdata_d = st_wdata;
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = LatInit;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = extract(rdata, off_q, f3_q);
        end
      end
      StResp: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign addr      = addr_q;
  assign wben      = wben_q;
  assign r_wn      = r_wn_q;
  assign wdata     = wdata_q;

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator side of the peripheral register bus.
- Accepts RISC-V-style load/store requests (byte address plus funct3 size code) from the core's load/store unit over a valid/ready handshake.
- Converts each request into a single bus cycle on addr/wben/r_wn/wdata, captures rdata after the fixed read latency, and returns lane-extracted, sign/zero-extended data over a valid/ready response channel.
- Flags illegal, misaligned or unsupported-lane accesses as errors without touching the bus.

Parameters:
RD_LATENCY, 1, cycles from a bus read being presented to rdata being valid (1..7)

Ports:
clk  input  1  master clock
reset  input  1  synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  high only in IDLE
req_we  input  1  1=store, 0=load
req_addr  input  5  byte address within 32-byte register space
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  access rejected
addr  output  3  bus word address (req_addr[4:2])
wben  output  2  bus byte-lane write enables
r_wn  output  1  1=read/idle, 0=write
wdata  output  32  bus write data
rdata  input  32  bus read data, registered by the responder

Behaviour:
- Bus idle state is r_wn=1, wben=00, wdata=0, addr holding its last value. The responder acts every cycle, so r_wn=0 is asserted for exactly one cycle per store and never otherwise.
- Reset values: req_ready=0 during reset and 1 in the first cycle after reset; rsp_valid=0, rsp_rdata=0, rsp_err=0, addr=0, wben=00, r_wn=1, wdata=0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when req_valid&&req_ready, latch the request and decode it.
  - Legal request -> ISSUE.
  - Illegal request -> RESP with rsp_err=1 and rsp_rdata=0; no bus activity.
- Legality rules:
  - funct3 011, 110 or 111 is illegal.
  - Store with funct3 100 or 101 is illegal.
  - H/HU requires req_addr[0]=0.
  - W requires req_addr[1:0]=00.
  - A store must fit lanes 0-1: SB offset 2 or 3 is illegal; SH offset 2 is illegal.
- Store lane mapping:
  - SB offset 0 -> wben=01, wdata[7:0]=byte.
  - SB offset 1 -> wben=10, wdata[15:8]=byte.
  - SH -> wben=11, wdata[15:0]=half.
  - SW -> wben=11, wdata=req_wdata.
  - Unused wdata bits are 0.
- ISSUE (one cycle): drive addr=req_addr[4:2].
  - Store: r_wn=0 with the mapped wben/wdata, then -> RESP.
  - Load: r_wn=1, wben=00, load counter with RD_LATENCY, then -> WAIT.
- WAIT: decrement the counter. When it reaches 0, capture rdata, extract and extend, then -> RESP.
- Load extraction:
  - B/BU take rdata[8*off+7:8*off].
  - H/HU take rdata[16*addr[1]+15:16*addr[1]].
  - B and H are sign-extended; BU and HU are zero-extended.
- Latency with RD_LATENCY=1, counted from the accept edge:
  - Store: rsp_valid asserted 2 cycles later.
  - Load: rsp_valid asserted 3 cycles later.
  - Error: rsp_valid asserted 1 cycle later.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; on that edge clear rsp_valid and -> IDLE. req_ready rises the following cycle, so there is no same-cycle back-to-back acceptance.
- Once accepted, a request is never dropped; rsp_ready low stalls indefinitely in RESP.
- Reset mid-operation in any state aborts the transaction with no response. The bus returns to idle on the same edge, so a store in ISSUE never completes if reset is high that cycle.

Test Plan:
1. LW at addr 0x00, responder holding 0x48524A44 at word 0 -> one read cycle with addr=000; rsp_rdata=0x48524A44, rsp_err=0, rsp_valid exactly 3 cycles after accept.
2. SB at addr 0x15 with req_wdata=0x000000A5 -> single cycle with r_wn=0, addr=101, wben=10, wdata=0x0000A500; rsp_rdata=0, rsp_err=0.
3. LB and LBU at addr 0x19 with word 6 = 0x1234F680 -> LB returns 0xFFFFFFF6, LBU returns 0x000000F6; LH at 0x1A returns 0x00001234.
4. LW at 0x06, SH at 0x0A, and funct3=011 each -> rsp_err=1, rsp_rdata=0, r_wn stays 1 and wben stays 00 throughout, rsp_valid 1 cycle after accept.
5. rsp_ready held low for 5 cycles after a load -> rsp fields stable, req_ready=0 throughout; req_ready=1 one cycle after the rsp_ready handshake.
6. Reset asserted while in WAIT -> next cycle shows rsp_valid=0, r_wn=1, wben=00; no response emitted; req_ready=1 the cycle after reset deasserts.
